// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared constants and encodings for the LDPC iteration sequencer
// Purpose: FSM state codes, datapath phase encoding and default array geometry
//          used by ldpc_iter_ctrl and its write-back delay line.
// Ports:   none (package).
package ldpc_pkg;

  localparam int LDPC_L_DEF = 32;
  localparam int LDPC_K_DEF = 6;
  localparam int LDPC_J_DEF = 3;

  typedef logic [2:0] ldpc_state_t;

  localparam ldpc_state_t ST_IDLE   = 3'd0;
  localparam ldpc_state_t ST_LOAD   = 3'd1;
  localparam ldpc_state_t ST_CNU    = 3'd2;
  localparam ldpc_state_t ST_VNU    = 3'd3;
  localparam ldpc_state_t ST_CHECK  = 3'd4;
  localparam ldpc_state_t ST_OUTPUT = 3'd5;

  // Which node-update phase currently owns the read address bus.
  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_CNU  = 2'd1,
    PH_VNU  = 2'd2
  } ldpc_phase_e;

endpackage

// File: rtl/ldpc_delay_line.sv
// rtl/ldpc_delay_line.sv - fixed-depth shift register aligning write-back with the CNU pipeline
// Purpose: delays a {valid, addr} word by DEPTH cycles; flush clears every stage.
// Ports:   clk, reset_n (async, active low), flush (sync clear),
//          in_data [W-1:0] word entering, out_data [W-1:0] word DEPTH cycles later.
module ldpc_delay_line #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_data
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = flush ? '0 : in_data;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = flush ? '0 : stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign out_data = stage_q[DEPTH-1];

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// rtl/ldpc_iter_ctrl.sv - LOAD -> (CNU -> VNU)xN -> OUTPUT iteration sequencer
// Purpose: drives memory address buses and CNU/VNU phase enables of the
//          block-serial LDPC decoder, with early exit on satisfied parity.
// Ports:   start/abort/max_iter control; load_valid/load_ready/load_addr intrinsic load;
//          rd_addr, wr_addr/wr_en, cnu_en/vnu_en datapath; parity_valid/parity_ok
//          from CNU banks; out_valid/out_ready/out_addr unload; iter_cnt, busy,
//          converged, done status.
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int L          = LDPC_L_DEF,
  parameter int ADDR_WIDTH = 5,
  parameter int K          = LDPC_K_DEF,
  parameter int J          = LDPC_J_DEF,
  parameter int PIPE_LAT   = 4,
  parameter int ITER_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [ADDR_WIDTH-1:0] load_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic                  cnu_en,
  output logic                  vnu_en,
  input  logic                  parity_valid,
  input  logic [J*K-1:0]        parity_ok,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ITER_WIDTH-1:0] iter_cnt,
  output logic                  busy,
  output logic                  converged,
  output logic                  done
);

  // Each phase reads for L cycles then idles PIPE_LAT cycles so the last
  // write-back lands before the next phase starts reading.
  localparam int                    PH_LEN    = L + PIPE_LAT;
  localparam int                    PH_W      = $clog2(PH_LEN + 1);
  localparam logic [PH_W-1:0]       PH_LAST   = PH_W'(PH_LEN - 1);
  localparam logic [PH_W-1:0]       PH_RD_END = PH_W'(L);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(L - 1);

  ldpc_state_t             state_q, state_d;
  logic [PH_W-1:0]         phase_cnt_q, phase_cnt_d;
  logic [ADDR_WIDTH-1:0]   load_cnt_q, load_cnt_d;
  logic [ADDR_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [ITER_WIDTH-1:0]   iter_cnt_q, iter_cnt_d;
  logic [ITER_WIDTH-1:0]   limit_q, limit_d;
  logic                    acc_q, acc_d;
  logic                    seen_q, seen_d;
  logic                    converged_q, converged_d;
  logic                    done_q, done_d;
  logic [ITER_WIDTH:0]     iter_inc;
  ldpc_phase_e             phase;
  logic                    rd_active;
  logic                    flush;
  logic [ADDR_WIDTH:0]     wb_out;

  always_comb begin
    phase = PH_NONE;
    if (state_q == ST_CNU) phase = PH_CNU;
    else if (state_q == ST_VNU) phase = PH_VNU;
  end

  assign rd_active = (phase != PH_NONE) && (phase_cnt_q < PH_RD_END);
  assign cnu_en    = rd_active && (phase == PH_CNU);
  assign vnu_en    = rd_active && (phase == PH_VNU);
  assign rd_addr   = rd_active ? ADDR_WIDTH'(phase_cnt_q) : '0;
  assign flush     = abort && (state_q != ST_IDLE);

  ldpc_delay_line #(
    .DEPTH (PIPE_LAT),
    .W     (ADDR_WIDTH + 1)
  ) u_wb_delay (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_data  ({rd_active, rd_addr}),
    .out_data (wb_out)
  );

  assign wr_en   = wb_out[ADDR_WIDTH];
  assign wr_addr = wb_out[ADDR_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    load_cnt_d  = load_cnt_q;
    out_cnt_d   = out_cnt_q;
    iter_cnt_d  = iter_cnt_q;
    limit_d     = limit_q;
    acc_d       = acc_q;
    seen_d      = seen_q;
    converged_d = converged_q;
    done_d      = 1'b0;
    iter_inc    = {1'b0, iter_cnt_q} + (ITER_WIDTH+1)'(1);

    if (flush) begin
      state_d     = ST_IDLE;
      phase_cnt_d = '0;
      load_cnt_d  = '0;
      out_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // abort in the same cycle suppresses the start
          if (start && !abort) begin
            state_d     = ST_LOAD;
            load_cnt_d  = '0;
            iter_cnt_d  = '0;
            converged_d = 1'b0;
            limit_d     = (max_iter == '0) ? ITER_WIDTH'(1) : max_iter;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            if (load_cnt_q == ADDR_LAST) begin
              state_d     = ST_CNU;
              load_cnt_d  = '0;
              phase_cnt_d = '0;
              acc_d       = 1'b1;
              seen_d      = 1'b0;
            end else begin
              load_cnt_d = load_cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_CNU: begin
          if (parity_valid) begin
            acc_d  = acc_q & (&parity_ok);
            seen_d = 1'b1;
          end
          if (phase_cnt_q == PH_LAST) begin
            state_d     = ST_VNU;
            phase_cnt_d = '0;
          end else begin
            phase_cnt_d = phase_cnt_q + PH_W'(1);
          end
        end
        ST_VNU: begin
          if (phase_cnt_q == PH_LAST) begin
            state_d     = ST_CHECK;
            phase_cnt_d = '0;
          end else begin
            phase_cnt_d = phase_cnt_q + PH_W'(1);
          end
        end
        ST_CHECK: begin
          iter_cnt_d  = iter_inc[ITER_WIDTH] ? '1 : iter_inc[ITER_WIDTH-1:0];
          converged_d = acc_q & seen_q;
          if ((acc_q && seen_q) || (iter_inc >= {1'b0, limit_q})) begin
            state_d   = ST_OUTPUT;
            out_cnt_d = '0;
          end else begin
            state_d     = ST_CNU;
            phase_cnt_d = '0;
            acc_d       = 1'b1;
            seen_d      = 1'b0;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            if (out_cnt_q == ADDR_LAST) begin
              state_d   = ST_IDLE;
              out_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              out_cnt_d = out_cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      phase_cnt_q <= '0;
      load_cnt_q  <= '0;
      out_cnt_q   <= '0;
      iter_cnt_q  <= '0;
      limit_q     <= '0;
      acc_q       <= 1'b0;
      seen_q      <= 1'b0;
      converged_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      load_cnt_q  <= load_cnt_d;
      out_cnt_q   <= out_cnt_d;
      iter_cnt_q  <= iter_cnt_d;
      limit_q     <= limit_d;
      acc_q       <= acc_d;
      seen_q      <= seen_d;
      converged_q <= converged_d;
      done_q      <= done_d;
    end
  end

  assign load_ready = (state_q == ST_LOAD);
  assign load_addr  = load_cnt_q;
  assign out_valid  = (state_q == ST_OUTPUT);
  assign out_addr   = out_cnt_q;
  assign iter_cnt   = iter_cnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign converged  = converged_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb/tb_ldpc_iter_ctrl.sv - self-checking bench for ldpc_iter_ctrl
module tb_ldpc_iter_ctrl;

  localparam int L  = 32;
  localparam int AW = 5;
  localparam int K  = 6;
  localparam int J  = 3;
  localparam int PL = 4;
  localparam int IW = 6;
  localparam int PH = L + PL;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IW-1:0] max_iter = '0;
  logic          load_valid = 1'b0;
  logic          parity_valid = 1'b0;
  logic [J*K-1:0] parity_ok = '0;
  logic          out_ready = 1'b0;
  logic          load_ready, wr_en, cnu_en, vnu_en, out_valid, busy, converged, done;
  logic [AW-1:0] load_addr, rd_addr, wr_addr, out_addr;
  logic [IW-1:0] iter_cnt;

  int errors = 0;
  int checks = 0;
  int exp_iter = 0;
  int exp_conv = 0;
  bit stopped;
  int lim, cv;

  always #5 clk = ~clk;

  ldpc_iter_ctrl #(
    .L(L), .ADDR_WIDTH(AW), .K(K), .J(J), .PIPE_LAT(PL), .ITER_WIDTH(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .max_iter(max_iter),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_en(wr_en), .cnu_en(cnu_en), .vnu_en(vnu_en),
    .parity_valid(parity_valid), .parity_ok(parity_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .iter_cnt(iter_cnt), .busy(busy), .converged(converged), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic logic [J*K-1:0] rand_bad();
    logic [J*K-1:0] v;
    v = (J*K)'($urandom);
    v[$urandom_range(0, J*K-1)] = 1'b0;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_cnu"}, 32'(cnu_en), 0);
    check({tag, "_vnu"}, 32'(vnu_en), 0);
    check({tag, "_rd"}, 32'(rd_addr), 0);
    check({tag, "_wren"}, 32'(wr_en), 0);
    check({tag, "_wra"}, 32'(wr_addr), 0);
    check({tag, "_ldrdy"}, 32'(load_ready), 0);
    check({tag, "_ldaddr"}, 32'(load_addr), 0);
    check({tag, "_oval"}, 32'(out_valid), 0);
    check({tag, "_oaddr"}, 32'(out_addr), 0);
    check({tag, "_iter"}, 32'(iter_cnt), 0);
    check({tag, "_conv"}, 32'(converged), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Expected datapath outputs at position p (0..2*PH-1) within one iteration.
  task automatic check_phase(input int p);
    int q, ra, wa, ce, ve, we;
    q  = p % PH;
    ce = (p < L) ? 1 : 0;
    ve = (p >= PH && p < PH + L) ? 1 : 0;
    ra = ce ? p : (ve ? p - PH : 0);
    we = (q >= PL) ? 1 : 0;
    wa = we ? q - PL : 0;
    check("ph_cnu_en", 32'(cnu_en), ce);
    check("ph_vnu_en", 32'(vnu_en), ve);
    check("ph_rd_addr", 32'(rd_addr), ra);
    check("ph_wr_en", 32'(wr_en), we);
    check("ph_wr_addr", 32'(wr_addr), wa);
    check("ph_busy", 32'(busy), 1);
    check("ph_out_valid", 32'(out_valid), 0);
    check("ph_load_ready", 32'(load_ready), 0);
  endtask

  task automatic do_start(input int mi);
    start = 1'b1;
    max_iter = IW'(mi);
    @(negedge clk);
    start = 1'b0;
    max_iter = IW'($urandom);
    exp_iter = 0;
    exp_conv = 0;
    check("start_load_ready", 32'(load_ready), 1);
    check("start_busy", 32'(busy), 1);
    check("start_iter", 32'(iter_cnt), 0);
    check("start_conv", 32'(converged), 0);
  endtask

  task automatic do_load(input bit inject_start);
    int beat, cyc;
    bit v;
    beat = 0;
    cyc = 0;
    while (beat < L && cyc < 400) begin
      check("load_ready", 32'(load_ready), 1);
      check("load_addr", 32'(load_addr), beat);
      check("load_cnu", 32'(cnu_en), 0);
      v = ($urandom_range(0, 3) != 0);
      load_valid = v;
      if (inject_start && cyc == 3) begin
        start = 1'b1;
        max_iter = IW'(5);
      end
      @(negedge clk);
      start = 1'b0;
      if (v) beat++;
      cyc++;
    end
    load_valid = 1'b0;
    check("load_beats", 32'(beat), L);
  endtask

  task automatic do_stop(input int kind);
    start = 1'b0;
    parity_valid = 1'b0;
    parity_ok = '0;
    if (kind == 1) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_cnu", 32'(cnu_en), 0);
      check("abort_vnu", 32'(vnu_en), 0);
      check("abort_wren", 32'(wr_en), 0);
      check("abort_oval", 32'(out_valid), 0);
      check("abort_done", 32'(done), 0);
      repeat (8) begin
        @(negedge clk);
        check("post_abort_wren", 32'(wr_en), 0);
        check("post_abort_done", 32'(done), 0);
        check("post_abort_busy", 32'(busy), 0);
      end
    end else begin
      reset_n = 1'b0;
      #1;
      check("rst_async_busy", 32'(busy), 0);
      check("rst_async_cnu", 32'(cnu_en), 0);
      @(posedge clk);
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (6) begin
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_wren", 32'(wr_en), 0);
      end
      exp_iter = 0;
      exp_conv = 0;
    end
  endtask

  // Iterations exit after the first one whose CNU phase saw only all-ones
  // parity (conv_it), or once the completed count reaches lim.
  task automatic run_iters(input int lim_in, input int conv_it, input int stop_kind,
                           input int stop_p, output bit was_stopped);
    was_stopped = 1'b0;
    for (int it = 1; it <= 64; it++) begin
      for (int p = 0; p < 2 * PH; p++) begin
        check_phase(p);
        if (it == 1 && stop_kind != 0 && p == stop_p) begin
          do_stop(stop_kind);
          was_stopped = 1'b1;
          return;
        end
        start = (p == 20);
        max_iter = IW'($urandom);
        if (p < PH) begin
          parity_valid = (p == 3) || ($urandom_range(0, 1) == 1);
          parity_ok = (it == conv_it) ? '1 : rand_bad();
        end else begin
          parity_valid = ($urandom_range(0, 1) == 1);
          parity_ok = '1;
        end
        @(negedge clk);
      end
      start = 1'b0;
      parity_valid = 1'b0;
      parity_ok = '0;
      check("chk_cnu", 32'(cnu_en), 0);
      check("chk_vnu", 32'(vnu_en), 0);
      check("chk_wren", 32'(wr_en), 0);
      check("chk_busy", 32'(busy), 1);
      check("chk_iter_before", 32'(iter_cnt), it - 1);
      @(negedge clk);
      check("iter_after", 32'(iter_cnt), it);
      if (it == conv_it || it >= lim_in) begin
        exp_iter = it;
        exp_conv = (it == conv_it) ? 1 : 0;
        check("exit_conv", 32'(converged), exp_conv);
        check("exit_out_valid", 32'(out_valid), 1);
        return;
      end
      check("cont_out_valid", 32'(out_valid), 0);
      check("cont_conv", 32'(converged), 0);
    end
  endtask

  task automatic do_output(input bit toggle);
    int beat, cyc;
    bit rdy;
    beat = 0;
    cyc = 0;
    while (beat < L && cyc < 400) begin
      check("out_valid", 32'(out_valid), 1);
      check("out_addr", 32'(out_addr), beat);
      check("out_done_early", 32'(done), 0);
      check("out_iter", 32'(iter_cnt), exp_iter);
      check("out_conv", 32'(converged), exp_conv);
      rdy = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);
      out_ready = rdy;
      @(negedge clk);
      if (rdy) beat++;
      cyc++;
    end
    out_ready = 1'b0;
    check("out_beats", 32'(beat), L);
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_oval", 32'(out_valid), 0);
    check("done_iter", 32'(iter_cnt), exp_iter);
    check("done_conv", 32'(converged), exp_conv);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("hold_iter", 32'(iter_cnt), exp_iter);
    check("hold_conv", 32'(converged), exp_conv);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    start = 1'b1;
    abort = 1'b1;
    max_iter = IW'(2);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_ldrdy", 32'(load_ready), 0);

    do_start(3);
    do_load(1'b0);
    run_iters(3, 0, 0, 0, stopped);
    do_output(1'b1);

    do_start(10);
    do_load(1'b0);
    run_iters(10, 2, 0, 0, stopped);
    do_output(1'b0);

    do_start(0);
    do_load(1'b1);
    run_iters(1, 0, 0, 0, stopped);
    do_output(1'b0);

    do_start(4);
    do_load(1'b0);
    run_iters(4, 0, 1, PH + 5, stopped);
    check("abort_taken", 32'(stopped), 1);

    do_start(4);
    do_load(1'b0);
    run_iters(4, 0, 2, 10, stopped);
    check("reset_taken", 32'(stopped), 1);

    repeat (2) begin
      lim = $urandom_range(1, 4);
      cv = $urandom_range(0, 4);
      do_start(lim);
      do_load(1'b0);
      run_iters(lim, cv, 0, 0, stopped);
      do_output(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
